dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- ADDR_W, 12, dmem word-address width
- DATA_W, 32, data width
- MAX_LOCK, 16, maximum consecutive cycles requester 1 holds the dmem under lock

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clock  in  1  single clock, rising edge; dmem is clocked on the same edge
- reset  in  1  asynchronous, active-low reset
- p0_req  in  1  processor access request
- p0_wren  in  1  processor write (1) / read (0)
- p0_addr  in  ADDR_W  processor address
- p0_wdata  in  DATA_W  processor write data
- p0_gnt  out  1  processor access accepted this cycle
- p0_rvalid  out  1  processor read data valid
- p0_rdata  out  DATA_W  processor read data
- p1_req  in  1  loader/debug request
- p1_wren  in  1  loader write (1) / read (0)
- p1_lock  in  1  loader requests back-to-back ownership
- p1_addr  in  ADDR_W  loader address
- p1_wdata  in  DATA_W  loader write data
- p1_gnt  out  1  loader access accepted this cycle
- p1_rvalid  out  1  loader read data valid
- p1_rdata  out  DATA_W  loader read data
- mem_address  out  ADDR_W  to dmem address
- mem_data  out  DATA_W  to dmem write data
- mem_wren  out  1  to dmem write enable
- mem_q  in  DATA_W  from dmem, valid one cycle after the read address is presented
- busy  out  1  a read response is pending

Function
REQ-003 Grants SHALL be combinational from the current reqs and registered state; at most one of p0_gnt/p1_gnt SHALL be high in any cycle.
REQ-004 A grant SHALL be issued only to an asserting requester; the requester is accepted at the rising edge closing a granted cycle.
REQ-005 With only one requester asserting, that requester SHALL be granted in the same cycle (zero-wait).
REQ-006 With both asserting and no active lock, the requester not granted most recently (last_gnt register) SHALL win; last_gnt updates on every grant.
REQ-007 mem_address and mem_data SHALL mux the granted requester's addr/wdata; mem_wren = granted wren; with no grant, mem_wren SHALL be 0 and mem_address/mem_data SHALL hold the p0 values.
REQ-008 A granted read SHALL produce rvalid for that requester exactly one cycle later, with rdata = mem_q; a tag register records the owner; writes produce no rvalid.
REQ-009 p0_rdata and p1_rdata SHALL both drive mem_q; only the rvalid identifies the owner.
REQ-010 Back-to-back reads, including alternating owners, SHALL be supported at one access per cycle with no bubble.
REQ-011 Lock: a granted p1 access with p1_lock=1 SHALL put the arbiter in LOCKED; in LOCKED, p1 SHALL win every cycle it requests, and p0 SHALL be granted only in cycles where p1_req=0.
REQ-012 A lock counter SHALL count granted p1 cycles in LOCKED; when it reaches MAX_LOCK, or p1_lock falls, the state SHALL return to IDLE, the counter SHALL clear, and last_gnt SHALL be 1 so p0 wins the next contention.
REQ-013 On exit from LOCKED on the count limit, p1 SHALL NOT re-enter LOCKED until a cycle with p1_lock=0 has been observed.
REQ-014 States: IDLE (round-robin), LOCKED, LOCK_BLOCKED (limit hit, awaiting p1_lock low; arbitrates as IDLE).
REQ-015 busy SHALL equal p0_rvalid|p1_rvalid pending, i.e. the registered read-issued flag.

Reset
REQ-016 reset low SHALL asynchronously force state=IDLE, lock counter=0, last_gnt=1 (p0 wins first tie), rvalid flags=0, busy=0.
REQ-017 During reset, p0_gnt, p1_gnt and mem_wren SHALL be 0 regardless of the requests.
REQ-018 A read granted in the cycle before reset asserts SHALL produce no rvalid after reset.

Verification
REQ-019 p0 read-only at 0x010, dmem[0x010]=0xDEADBEEF -> p0_gnt same cycle; p0_rvalid=1 with p0_rdata=0xDEADBEEF next cycle; p1 outputs 0.
REQ-020 Both request every cycle, no lock, from reset -> grants alternate p0,p1,p0,p1; never both high.
REQ-021 p1 write 0x055=0x12345678 while p0 reads 0x055 in the following cycle -> mem_wren=1 in p1 cycle; p0_rvalid returns 0x12345678.
REQ-022 p1_lock held with p1_req=1 for 20 cycles, p0_req=1 -> p1 granted 16 consecutive cycles, then p0 granted; alternation until p1_lock drops.
REQ-023 Reset asserted mid-read (grant issued, edge taken) -> rvalid never asserts; after release, the first tie goes to p0.
REQ-024 Locked p1 deasserts p1_req for one cycle -> p0 granted that cycle; lock is retained and the counter is not advanced.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory.
// Port 0 is the processor, port 1 the loader/debug master. Arbitration is
// round-robin, except that port 1 may lock the memory for a bounded burst.
// Read data returns one cycle after the grant, tagged with its owner.
module dmem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 16   // expected to be at least 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_wren,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_wren,
    input  logic              p1_lock,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        LOCKED       = 2'd1,
        LOCK_BLOCKED = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   lock_cnt, lock_cnt_nxt;
    logic               last_gnt, last_gnt_nxt;   // 1: port 1 granted most recently
    logic               rd_vld;                   // a read was issued last cycle
    logic               rd_tag;                   // owner of that read (1: port 1)

    // State register: FSM state, burst counter and round-robin pointer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            lock_cnt <= '0;
            last_gnt <= 1'b1;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    // Next-state logic: lock entry, burst counting, exit and re-arm
    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        last_gnt_nxt = last_gnt;
        if (p0_gnt) last_gnt_nxt = 1'b0;
        if (p1_gnt) last_gnt_nxt = 1'b1;
        case (state)
            IDLE: begin
                // The grant that takes the lock is the first of the burst.
                if (p1_gnt && p1_lock) begin
                    state_nxt    = LOCKED;
                    lock_cnt_nxt = CNT_W'(1);
                end
            end
            LOCKED: begin
                if (!p1_lock) begin
                    state_nxt    = IDLE;
                    lock_cnt_nxt = '0;
                    last_gnt_nxt = 1'b1;
                end else if (p1_gnt) begin
                    if (lock_cnt == CNT_W'(MAX_LOCK - 1)) begin
                        // Burst exhausted: hand the next tie to port 0 and
                        // refuse a new lock until port 1 drops p1_lock.
                        state_nxt    = LOCK_BLOCKED;
                        lock_cnt_nxt = '0;
                        last_gnt_nxt = 1'b1;
                    end else begin
                        lock_cnt_nxt = lock_cnt + CNT_W'(1);
                    end
                end
            end
            LOCK_BLOCKED: begin
                if (!p1_lock) state_nxt = IDLE;
            end
            default: begin
                state_nxt    = IDLE;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    // Output logic: grants and memory-side mux, all forced idle in reset
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (reset) begin
            if (state == LOCKED) begin
                p1_gnt = p1_req;
                p0_gnt = p0_req && !p1_req;
            end else if (p0_req && p1_req) begin
                p0_gnt = last_gnt;
                p1_gnt = !last_gnt;
            end else begin
                p0_gnt = p0_req;
                p1_gnt = p1_req;
            end
        end
        mem_address = p1_gnt ? p1_addr  : p0_addr;
        mem_data    = p1_gnt ? p1_wdata : p0_wdata;
        mem_wren    = (p0_gnt && p0_wren) || (p1_gnt && p1_wren);
    end

    // Read-response tracking: one outstanding read, owner recorded by tag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_vld <= 1'b0;
            rd_tag <= 1'b0;
        end else begin
            rd_vld <= (p0_gnt && !p0_wren) || (p1_gnt && !p1_wren);
            rd_tag <= p1_gnt;
        end
    end

    assign p0_rvalid = rd_vld && !rd_tag;
    assign p1_rvalid = rd_vld && rd_tag;
    assign p0_rdata  = mem_q;
    assign p1_rdata  = mem_q;
    assign busy      = rd_vld;

endmodule
